fpga_logic_cell: RTL and testbench

- One FPGA fabric cell: a 5-input LUT logic tile with an optional output register, plus a 4x4 programmable switch box.
- All programming bits (LUT contents, output mode, switch matrix) are held in one 49-bit configuration shift chain.
- Cells are daisy-chained on the chain through cfg_in/cfg_out and placed in a tile array.

---
 rtl/fpga_logic_cell.sv | 101 ++++++++++
 tb/tb_fpga_logic_cell.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_logic_cell.sv
// -----------------------------------------------------------------------------
// fpga_logic_cell
//
// One fabric cell: a 5-input LUT tile with a selectable output register and a
// 4x4 programmable switch box. All programming state sits in one 49-bit serial
// configuration chain, so cells can be daisy-chained through cfg_in/cfg_out.
//
// Chain layout (cfg_r):
//   [15:0]  switch matrix, bit 4i+j connects sb_in[j] to sb_out[i]
//   [47:16] LUT truth table, entry k at bit 16+k
//   [48]    output mode (0 = combinational, 1 = registered)
//
// Ports:
//   clock    rising-edge clock for the chain and the output register
//   reset    asynchronous, active-high; clears chain and output register
//   cfg_en   shift enable for the configuration chain
//   cfg_in   serial configuration data in (enters at cfg_r[0])
//   cfg_out  serial configuration data out (cfg_r[48])
//   in1..in5 LUT select, in1 is the LSB of the index
//   lt_out   logic tile output
//   sb_in    switch box inputs [3:0]
//   sb_out   switch box outputs [3:0]
//
// There is no shadow copy of the configuration: while the chain is shifting,
// the LUT, mode and switch matrix follow the partially loaded bits.
// -----------------------------------------------------------------------------
module fpga_logic_cell (
    input  logic       clock,
    input  logic       reset,
    input  logic       cfg_en,
    input  logic       cfg_in,
    output logic       cfg_out,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       in4,
    input  logic       in5,
    output logic       lt_out,
    input  logic [3:0] sb_in,
    output logic [3:0] sb_out
);

    localparam int CFG_LEN = 49;
    localparam int LUT_K   = 5;
    localparam int SB_N    = 4;

    logic [CFG_LEN-1:0]      cfg_r;
    logic                    q_r;
    logic [15:0]             sw_s;
    logic [(1<<LUT_K)-1:0]   lut_s;
    logic                    mode_s;
    logic [LUT_K-1:0]        idx_s;
    logic                    lut_val_s;

    // Field views of the configuration chain
    assign sw_s    = cfg_r[15:0];
    assign lut_s   = cfg_r[47:16];
    assign mode_s  = cfg_r[48];
    assign cfg_out = cfg_r[48];

    assign idx_s     = {in5, in4, in3, in2, in1};
    assign lut_val_s = lut_s[idx_s];

    // Configuration shift chain: new bits enter at bit 0 and move toward bit 48
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_r <= {CFG_LEN{1'b0}};
        end else if (cfg_en) begin
            cfg_r <= {cfg_r[CFG_LEN-2:0], cfg_in};
        end else begin
            cfg_r <= cfg_r;
        end
    end

    // Output register samples the LUT every cycle, independent of mode and cfg_en
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_r <= 1'b0;
        end else begin
            q_r <= lut_val_s;
        end
    end

    // Output mux: mode selects registered or direct LUT value
    always_comb begin
        if (mode_s) begin
            lt_out = q_r;
        end else begin
            lt_out = lut_val_s;
        end
    end

    // Switch box: each output is the wired-OR of the inputs its nibble selects
    always_comb begin
        sb_out = 4'b0000;
        for (int i = 0; i < SB_N; i++) begin
            sb_out[i] = |(sw_s[4*i +: 4] & sb_in);
        end
    end

endmodule

// File: tb/tb_fpga_logic_cell.sv
// -----------------------------------------------------------------------------
// tb_fpga_logic_cell
//
// Directed self-checking bench for fpga_logic_cell. Inputs change 1 time unit
// after a rising edge; outputs are sampled away from the clock edge.
// -----------------------------------------------------------------------------
module tb_fpga_logic_cell;

    logic       clock;
    logic       reset;
    logic       cfg_en;
    logic       cfg_in;
    logic       cfg_out;
    logic       in1, in2, in3, in4, in5;
    logic       lt_out;
    logic [3:0] sb_in;
    logic [3:0] sb_out;

    int n_checks;
    int n_fail;

    fpga_logic_cell dut (
        .clock   (clock),
        .reset   (reset),
        .cfg_en  (cfg_en),
        .cfg_in  (cfg_in),
        .cfg_out (cfg_out),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .in4     (in4),
        .in5     (in5),
        .lt_out  (lt_out),
        .sb_in   (sb_in),
        .sb_out  (sb_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive the LUT index {in5..in1}
    task automatic set_idx(input logic [4:0] v);
        {in5, in4, in3, in2, in1} = v;
    endtask

    // Shift a full 49-bit word, MSB first, so word[48] ends in the mode bit
    task automatic load_word(input logic [48:0] w);
        for (int i = 48; i >= 0; i--) begin
            cfg_in = w[i];
            cfg_en = 1'b1;
            @(posedge clock);
            #1;
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        sb_in  = 4'b1111;
        set_idx(5'b00000);
        #3;
        n_checks++;
        if (lt_out !== 1'b0) begin n_fail++; $display("FAIL reset_lt_out: got %b expected 0", lt_out); end
        n_checks++;
        if (sb_out !== 4'b0000) begin n_fail++; $display("FAIL reset_sb_out: got %b expected 0000", sb_out); end
        n_checks++;
        if (cfg_out !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_out: got %b expected 0", cfg_out); end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_lut_comb;
        load_word({1'b0, 32'h8000_0001, 16'h8421});
        set_idx(5'b00000); #1;
        n_checks++;
        if (lt_out !== 1'b1) begin n_fail++; $display("FAIL lut_idx0: got %b expected 1", lt_out); end
        set_idx(5'b11111); #1;
        n_checks++;
        if (lt_out !== 1'b1) begin n_fail++; $display("FAIL lut_idx31: got %b expected 1", lt_out); end
        set_idx(5'b10101); #1;
        n_checks++;
        if (lt_out !== 1'b0) begin n_fail++; $display("FAIL lut_idx21: got %b expected 0", lt_out); end
        set_idx(5'b00001); #1;
        n_checks++;
        if (lt_out !== 1'b0) begin n_fail++; $display("FAIL lut_idx1: got %b expected 0", lt_out); end
        sb_in = 4'b1010; #1;
        n_checks++;
        if (sb_out !== 4'b1010) begin n_fail++; $display("FAIL sb_identity: got %b expected 1010", sb_out); end
        n_checks++;
        if (cfg_out !== 1'b0) begin n_fail++; $display("FAIL cfg_out_mode0: got %b expected 0", cfg_out); end
    endtask

    task automatic test_switch;
        load_word({1'b0, 32'h0000_0000, 16'h1111});
        sb_in = 4'b1111; #1;
        n_checks++;
        if (sb_out !== 4'b1111) begin n_fail++; $display("FAIL sb_fanout_1111: got %b expected 1111", sb_out); end
        sb_in = 4'b1110; #1;
        n_checks++;
        if (sb_out !== 4'b0000) begin n_fail++; $display("FAIL sb_fanout_1110: got %b expected 0000", sb_out); end
        load_word({1'b0, 32'h0000_0000, 16'h0000});
        sb_in = 4'b1111; #1;
        n_checks++;
        if (sb_out !== 4'b0000) begin n_fail++; $display("FAIL sb_zero_1111: got %b expected 0000", sb_out); end
        sb_in = 4'b0101; #1;
        n_checks++;
        if (sb_out !== 4'b0000) begin n_fail++; $display("FAIL sb_zero_0101: got %b expected 0000", sb_out); end
        load_word({1'b0, 32'h0000_0000, 16'h00F3});
        sb_in = 4'b1001; #1;
        n_checks++;
        if (sb_out !== 4'b0011) begin n_fail++; $display("FAIL sb_wired_or: got %b expected 0011", sb_out); end
        sb_in = 4'b0100; #1;
        n_checks++;
        if (sb_out !== 4'b0010) begin n_fail++; $display("FAIL sb_wired_or_in2: got %b expected 0010", sb_out); end
    endtask

    task automatic test_registered;
        load_word({1'b1, 32'hAAAA_AAAA, 16'hFFFF});
        n_checks++;
        if (cfg_out !== 1'b1) begin n_fail++; $display("FAIL cfg_out_mode1: got %b expected 1", cfg_out); end
        set_idx(5'b00000);
        @(posedge clock);
        #1;
        n_checks++;
        if (lt_out !== 1'b0) begin n_fail++; $display("FAIL reg_idx0: got %b expected 0", lt_out); end
        #3;
        in1 = 1'b1;
        #1;
        n_checks++;
        if (lt_out !== 1'b0) begin n_fail++; $display("FAIL reg_hold_midcycle: got %b expected 0", lt_out); end
        @(posedge clock);
        #1;
        n_checks++;
        if (lt_out !== 1'b1) begin n_fail++; $display("FAIL reg_after_edge: got %b expected 1", lt_out); end
    endtask

    task automatic test_async_reset;
        sb_in = 4'b1111;
        #1;
        n_checks++;
        if (sb_out !== 4'b1111) begin n_fail++; $display("FAIL pre_reset_sb_out: got %b expected 1111", sb_out); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (lt_out !== 1'b0) begin n_fail++; $display("FAIL async_reset_lt_out: got %b expected 0", lt_out); end
        n_checks++;
        if (sb_out !== 4'b0000) begin n_fail++; $display("FAIL async_reset_sb_out: got %b expected 0000", sb_out); end
        n_checks++;
        if (cfg_out !== 1'b0) begin n_fail++; $display("FAIL async_reset_cfg_out: got %b expected 0", cfg_out); end
        cfg_en = 1'b1;
        cfg_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            n_checks++;
            if (cfg_out !== 1'b0) begin n_fail++; $display("FAIL reset_shift_cfg_out[%0d]: got %b expected 0", k, cfg_out); end
        end
        #3;
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        reset  = 1'b0;
        #1;
        n_checks++;
        if (sb_out !== 4'b0000) begin n_fail++; $display("FAIL reset_shift_ignored_sb: got %b expected 0000", sb_out); end
        n_checks++;
        if (lt_out !== 1'b0) begin n_fail++; $display("FAIL reset_shift_ignored_lt: got %b expected 0", lt_out); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_chain;
        // Chain starts all-zero after the previous reset
        cfg_in = 1'b1;
        cfg_en = 1'b1;
        for (int k = 1; k <= 49; k++) begin
            @(posedge clock);
            #1;
            n_checks++;
            if (cfg_out !== (k >= 49)) begin n_fail++; $display("FAIL chain_ones[%0d]: got %b expected %b", k, cfg_out, (k >= 49)); end
        end
        cfg_in = 1'b0;
        for (int k = 1; k <= 49; k++) begin
            @(posedge clock);
            #1;
            n_checks++;
            if (cfg_out !== (k < 49)) begin n_fail++; $display("FAIL chain_zeros[%0d]: got %b expected %b", k, cfg_out, (k < 49)); end
        end
        cfg_en = 1'b0;
        // Hold: load a known pattern, then idle with cfg_in toggling
        load_word({1'b0, 32'h8000_0001, 16'h8421});
        for (int k = 0; k < 10; k++) begin
            cfg_in = k[0];
            @(posedge clock);
            #1;
        end
        sb_in = 4'b0110;
        set_idx(5'b11111);
        #1;
        n_checks++;
        if (sb_out !== 4'b0110) begin n_fail++; $display("FAIL hold_sb_out: got %b expected 0110", sb_out); end
        n_checks++;
        if (lt_out !== 1'b1) begin n_fail++; $display("FAIL hold_lt_idx31: got %b expected 1", lt_out); end
        set_idx(5'b00010);
        #1;
        n_checks++;
        if (lt_out !== 1'b0) begin n_fail++; $display("FAIL hold_lt_idx2: got %b expected 0", lt_out); end
        n_checks++;
        if (cfg_out !== 1'b0) begin n_fail++; $display("FAIL hold_cfg_out: got %b expected 0", cfg_out); end
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_lut_comb();
        test_switch();
        test_registered();
        test_async_reset();
        test_chain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
